// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin synchroniser and deglitch filter, 11-bit frame checker,
// E0/F0 prefix folding, and a first-word-fall-through event FIFO with valid/ready.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  output logic             o_key_valid,
  input  logic             i_key_ready,
  output logic [7:0]       o_key_code,
  output logic             o_key_ext,
  output logic             o_key_break,
  output logic             o_frame_err,
  output logic             o_overflow,
  output logic [LVL_W-1:0] o_fifo_level
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] raw_pins;
  logic [1:0] filt;
  assign raw_pins = {PS2_DATA, PS2_CLK};

  // Index 0 is the PS/2 clock, index 1 the PS/2 data line; both idle high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pin
      logic [1:0]    sync_q;
      logic          filt_q;
      logic [FW-1:0] cnt_q;

      always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
          sync_q <= 2'b11;
          filt_q <= 1'b1;
          cnt_q  <= '0;
        end else begin
          sync_q <= {sync_q[0], raw_pins[gi]};
          if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
          end else if (cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign filt[gi] = filt_q;
    end
  endgenerate

  logic clk_prev_q;
  logic strobe;
  logic bit_in;
  assign strobe = clk_prev_q & ~filt[0];
  assign bit_in = filt[1];

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] timer_q;
  logic          byte_done_q;
  logic          err_q;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      clk_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      timer_q     <= '0;
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_prev_q  <= filt[0];
      byte_done_q <= 1'b0;
      err_q       <= 1'b0;
      if (state_q == S_IDLE || strobe) timer_q <= '0;
      else                             timer_q <= timer_q + 1'b1;

      if (state_q != S_IDLE && !strobe && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end else if (strobe) begin
        case (state_q)
          S_IDLE: begin
            if (!bit_in) begin
              state_q  <= S_DATA;
              bitcnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q  <= {bit_in, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= bit_in;
            state_q <= S_STOP;
          end
          S_STOP: begin
            if (bit_in && (^shift_q ^ par_q)) byte_done_q <= 1'b1;
            else                              err_q       <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // shift_q holds the finished byte until the next frame starts shifting.
  logic ext_q, brk_q, ovf_q;
  logic push_req, pop, full, do_push;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [9:0]       head;

  assign push_req = byte_done_q && shift_q != CODE_EXT && shift_q != CODE_BRK;
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop      = o_key_valid & i_key_ready;
  assign do_push  = push_req & (~full | pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !pop)      level_d = level_q + 1'b1;
    else if (!do_push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      ovf_q   <= push_req & full & ~pop;
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_done_q) begin
        if (shift_q == CODE_EXT) begin
          ext_q <= 1'b1;
        end else if (shift_q == CODE_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (do_push) mem[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  // Head is gated so that stale RAM contents never appear while the FIFO is empty.
  assign head         = mem[rd_ptr_q];
  assign o_key_valid  = (level_q != '0);
  assign o_key_code   = o_key_valid ? head[7:0] : 8'h00;
  assign o_key_break  = o_key_valid & head[8];
  assign o_key_ext    = o_key_valid & head[9];
  assign o_frame_err  = err_q;
  assign o_overflow   = ovf_q;
  assign o_fifo_level = level_q;

endmodule
